// File: rtl/pipelined_carry_adder.sv
// ---------------------------------------------------------------------------
// pipelined_carry_adder
//
// Purpose:
//   Adds or subtracts two WIDTH-bit operands in STAGES equal slices of
//   SW = WIDTH/STAGES bits. Each pipeline stage adds one slice per clock and
//   registers the carry between slices. The bundle accepts one beat per cycle
//   under a valid/ready handshake. When the output is full and not being
//   taken, the whole pipeline stalls.
//
//   Add:       s = a + b + cin
//   Subtract:  s = a - b - cin, evaluated as a + ~b + !cin
//
//   For subtraction, cout is the raw carry of that sum, i.e. NOT borrow.
//   ovf flags two's-complement signed overflow.
//
// Parameters:
//   WIDTH   operand / result width (WIDTH must be a multiple of STAGES)
//   STAGES  pipeline depth = number of slices (latency in cycles)
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   operand beat valid
//   in_ready   beat can be accepted this cycle (combinational)
//   a, b       operands
//   cin        carry-in (add) / borrow-in (sub)
//   sub        0: add, 1: subtract
//   out_valid  result beat valid
//   out_ready  downstream accepts the result
//   s          result
//   cout       carry out of the top bit
//   ovf        signed overflow
// ---------------------------------------------------------------------------
module pipelined_carry_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int SW = WIDTH / STAGES;

  // Global advance: every stage moves together, or every stage holds.
  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             c0;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Subtraction is folded into the adder at capture time.
  assign b_eff = sub ? ~b : b;
  assign c0    = sub ? ~cin : cin;

  genvar gi;
  for (gi = 0; gi < STAGES; gi++) begin : g_stage
    // Slice inputs for this stage.
    logic [SW-1:0]          a_sl;
    logic [SW-1:0]          b_sl;
    logic                   c_in;
    logic                   v_in;

    // Slice adder output: {carry-out, SW sum bits}.
    logic [SW:0]            slice_add;

    // Completed low slices, including the one produced by this stage.
    logic [(gi+1)*SW-1:0]   sum_d;
    logic [(gi+1)*SW-1:0]   sum_q;
    logic                   v_q;
    logic                   c_q;

    if (gi == 0) begin : g_src
      assign a_sl  = a[SW-1:0];
      assign b_sl  = b_eff[SW-1:0];
      assign c_in  = c0;
      assign v_in  = in_valid;
      assign sum_d = slice_add[SW-1:0];
    end else begin : g_src
      // The lowest forwarded operand bits of the previous stage form this
      // stage's slice.
      assign a_sl  = g_stage[gi-1].g_fwd.a_fwd_q[SW-1:0];
      assign b_sl  = g_stage[gi-1].g_fwd.b_fwd_q[SW-1:0];
      assign c_in  = g_stage[gi-1].c_q;
      assign v_in  = g_stage[gi-1].v_q;
      assign sum_d = {slice_add[SW-1:0], g_stage[gi-1].sum_q};
    end

    assign slice_add = {1'b0, a_sl} + {1'b0, b_sl} + {{SW{1'b0}}, c_in};

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v_q   <= 1'b0;
        c_q   <= 1'b0;
        sum_q <= '0;
      end else if (adv) begin
        v_q   <= v_in;
        c_q   <= slice_add[SW];
        sum_q <= sum_d;
      end
    end

    // Operand skew: slices not yet consumed travel alongside the beat.
    // The final stage has nothing left to forward.
    if (gi < STAGES - 1) begin : g_fwd
      localparam int FW = WIDTH - (gi + 1) * SW;

      logic [FW-1:0] a_fwd_d;
      logic [FW-1:0] b_fwd_d;
      logic [FW-1:0] a_fwd_q;
      logic [FW-1:0] b_fwd_q;

      if (gi == 0) begin : g_fsrc
        assign a_fwd_d = a[WIDTH-1:SW];
        assign b_fwd_d = b_eff[WIDTH-1:SW];
      end else begin : g_fsrc
        assign a_fwd_d = g_stage[gi-1].g_fwd.a_fwd_q[FW+SW-1:SW];
        assign b_fwd_d = g_stage[gi-1].g_fwd.b_fwd_q[FW+SW-1:SW];
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_fwd_q <= '0;
          b_fwd_q <= '0;
        end else if (adv) begin
          a_fwd_q <= a_fwd_d;
          b_fwd_q <= b_fwd_d;
        end
      end
    end

    // The top slice also produces the signed-overflow flag. The carry into
    // the MSB equals a ^ b ^ sum at that bit. XORing it with the carry out
    // gives overflow.
    if (gi == STAGES - 1) begin : g_ovf
      logic ovf_d;
      logic ovf_q;

      assign ovf_d = a_sl[SW-1] ^ b_sl[SW-1] ^ slice_add[SW-1] ^ slice_add[SW];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          ovf_q <= 1'b0;
        end else if (adv) begin
          ovf_q <= ovf_d;
        end
      end
    end
  end

  // The final stage registers are the output registers.
  assign out_valid = g_stage[STAGES-1].v_q;
  assign s         = g_stage[STAGES-1].sum_q;
  assign cout      = g_stage[STAGES-1].c_q;
  assign ovf       = g_stage[STAGES-1].g_ovf.ovf_q;

endmodule

// File: tb/tb_pipelined_carry_adder.sv
// ---------------------------------------------------------------------------
// tb_pipelined_carry_adder
//
// Drives two instances from a shared stimulus:
//   dut_a  WIDTH=32, STAGES=4
//   dut_b  WIDTH=16, STAGES=1
//
// Each instance has a scoreboard fed by an arithmetic reference model.
// Directed vectors check exact values and latency. Hand-written sequences
// cover reset mid-stream and output backpressure.
// ---------------------------------------------------------------------------
module tb_pipelined_carry_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        tb_in_valid;
  logic [31:0] tb_a;
  logic [31:0] tb_b;
  logic        tb_cin;
  logic        tb_sub;
  logic        tb_out_ready;

  logic        in_ready_a;
  logic        out_valid_a;
  logic [31:0] s_a;
  logic        cout_a;
  logic        ovf_a;

  logic        in_ready_b;
  logic        out_valid_b;
  logic [15:0] s_b;
  logic        cout_b;
  logic        ovf_b;

  int n_cmp = 0;
  int n_err = 0;

  logic [63:0] q_a[$];
  logic [63:0] q_b[$];
  logic [31:0] seen_q[$];
  bit          cap_en = 1'b0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        ci;
    logic        sb;
    logic [31:0] es;
    logic        ec;
    logic        eo;
  } vec_t;

  vec_t vt[9];

  initial forever #5 clk = ~clk;

  pipelined_carry_adder #(.WIDTH(32), .STAGES(4)) dut_a (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (tb_in_valid),
    .in_ready  (in_ready_a),
    .a         (tb_a),
    .b         (tb_b),
    .cin       (tb_cin),
    .sub       (tb_sub),
    .out_valid (out_valid_a),
    .out_ready (tb_out_ready),
    .s         (s_a),
    .cout      (cout_a),
    .ovf       (ovf_a)
  );

  pipelined_carry_adder #(.WIDTH(16), .STAGES(1)) dut_b (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (tb_in_valid),
    .in_ready  (in_ready_b),
    .a         (tb_a[15:0]),
    .b         (tb_b[15:0]),
    .cin       (tb_cin),
    .sub       (tb_sub),
    .out_valid (out_valid_b),
    .out_ready (tb_out_ready),
    .s         (s_b),
    .cout      (cout_b),
    .ovf       (ovf_b)
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] pk(input logic o, input logic c, input logic [31:0] sv);
    return {30'd0, o, c, sv};
  endfunction

  // Reference: plain integer arithmetic on w-bit values.
  //   cout for subtraction = no borrow (a >= b + cin).
  //   ovf = exact signed result falls outside the w-bit range.
  function automatic logic [63:0] model(input int w, input logic [31:0] av, input logic [31:0] bv,
                                        input logic ci, input logic sb);
    longint mask;
    longint half;
    longint ua;
    longint ub;
    longint c;
    longint sum;
    longint sa;
    longint sbv;
    longint ss;
    logic   co;
    logic   ov;
    mask = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    ua   = longint'({32'd0, av}) & mask;
    ub   = longint'({32'd0, bv}) & mask;
    c    = longint'({63'd0, ci});
    if (sb) begin
      sum = ua - ub - c;
      co  = (ua >= ub + c);
    end else begin
      sum = ua + ub + c;
      co  = (sum > mask);
    end
    sa  = (ua >= half) ? ua - mask - 1 : ua;
    sbv = (ub >= half) ? ub - mask - 1 : ub;
    ss  = sb ? sa - sbv - c : sa + sbv + c;
    ov  = (ss >= half) || (ss < -half);
    return pk(ov, co, 32'(sum & mask));
  endfunction

  // Scoreboard / protocol monitor for dut_a.
  initial begin : mon_a
    logic [63:0] e;
    logic [63:0] hold;
    bit          st;
    st   = 1'b0;
    hold = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        q_a.delete();
        st = 1'b0;
      end else begin
        if (st) check("hold_a", pk(ovf_a, cout_a, s_a), hold);
        check("in_ready_a", 64'(in_ready_a), 64'(!out_valid_a || tb_out_ready));
        if (out_valid_a && tb_out_ready) begin
          if (q_a.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL spurious_a: got out_valid with s=0x%0h, expected no beat", s_a);
          end else begin
            e = q_a.pop_front();
            check("score_a", pk(ovf_a, cout_a, s_a), e);
          end
          if (cap_en) seen_q.push_back(s_a);
        end
        if (tb_in_valid && in_ready_a) q_a.push_back(model(32, tb_a, tb_b, tb_cin, tb_sub));
        st   = out_valid_a && !tb_out_ready;
        hold = pk(ovf_a, cout_a, s_a);
      end
    end
  end

  // Scoreboard / protocol monitor for dut_b.
  initial begin : mon_b
    logic [63:0] e;
    logic [63:0] hold;
    bit          st;
    st   = 1'b0;
    hold = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        q_b.delete();
        st = 1'b0;
      end else begin
        if (st) check("hold_b", pk(ovf_b, cout_b, {16'd0, s_b}), hold);
        check("in_ready_b", 64'(in_ready_b), 64'(!out_valid_b || tb_out_ready));
        if (out_valid_b && tb_out_ready) begin
          if (q_b.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL spurious_b: got out_valid with s=0x%0h, expected no beat", s_b);
          end else begin
            e = q_b.pop_front();
            check("score_b", pk(ovf_b, cout_b, {16'd0, s_b}), e);
          end
        end
        if (tb_in_valid && in_ready_b)
          q_b.push_back(model(16, {16'd0, tb_a[15:0]}, {16'd0, tb_b[15:0]}, tb_cin, tb_sub));
        st   = out_valid_b && !tb_out_ready;
        hold = pk(ovf_b, cout_b, {16'd0, s_b});
      end
    end
  end

  initial begin : main
    int i;
    int k;
    int lat;

    vt[0] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    vt[1] = '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
    vt[2] = '{32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1, 32'h0000_0001, 1'b1, 1'b0};
    vt[3] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
    vt[4] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
    vt[5] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0};
    vt[6] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
    vt[7] = '{32'h1234_5678, 32'h0FED_CBA9, 1'b0, 1'b0, 32'h2222_2221, 1'b0, 1'b0};
    vt[8] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1};

    rst          = 1'b1;
    tb_in_valid  = 1'b0;
    tb_a         = '0;
    tb_b         = '0;
    tb_cin       = 1'b0;
    tb_sub       = 1'b0;
    tb_out_ready = 1'b1;

    // Reset state.
    @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid_a), 64'(0));
    check("rst_s",         64'(s_a),         64'(0));
    check("rst_cout",      64'(cout_a),      64'(0));
    check("rst_ovf",       64'(ovf_a),       64'(0));
    check("rst_out_valid_b", 64'(out_valid_b), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_in_ready", 64'(in_ready_a), 64'(1));

    // Mid-stream reset: fill the pipeline against a stalled output,
    // then assert reset between clock edges.
    tb_out_ready = 1'b0;
    tb_in_valid  = 1'b1;
    tb_a         = 32'h1234_5678;
    tb_b         = 32'h1111_1111;
    repeat (6) @(posedge clk);
    #1;
    tb_in_valid = 1'b0;
    check("pre_rst_valid", 64'(out_valid_a), 64'(1));
    check("pre_rst_s",     64'(s_a),         64'(32'h2345_6789));
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", 64'(out_valid_a), 64'(0));
    check("mid_rst_s",         64'(s_a),         64'(0));
    check("mid_rst_cout",      64'(cout_a),      64'(0));
    check("mid_rst_ovf",       64'(ovf_a),       64'(0));
    check("mid_rst_out_valid_b", 64'(out_valid_b), 64'(0));
    @(posedge clk);
    #1;
    rst          = 1'b0;
    tb_out_ready = 1'b1;

    // Directed vectors: exact values and latency. The first vector is also
    // the first beat after the reset release.
    for (int v = 0; v < 9; v++) begin
      tb_a        = vt[v].a;
      tb_b        = vt[v].b;
      tb_cin      = vt[v].ci;
      tb_sub      = vt[v].sb;
      tb_in_valid = 1'b1;
      @(negedge clk);
      check("vec_in_ready", 64'(in_ready_a), 64'(1));
      @(posedge clk);
      #1;
      tb_in_valid = 1'b0;
      lat = 1;
      while (!out_valid_a && lat < 20) begin
        @(posedge clk);
        #1;
        lat++;
      end
      check("vec_latency", 64'(lat), 64'(4));
      check("vec_result", pk(ovf_a, cout_a, s_a), pk(vt[v].eo, vt[v].ec, vt[v].es));
      @(posedge clk);
      #1;
    end

    // Backpressure: 8 back-to-back beats, with out_ready cycling 1,0,0,1.
    seen_q.delete();
    cap_en = 1'b1;
    i = 0;
    k = 0;
    tb_cin = 1'b0;
    tb_sub = 1'b0;
    while ((i < 8 || seen_q.size() < 8) && k < 200) begin
      tb_in_valid  = (i < 8);
      tb_a         = 32'(i);
      tb_b         = 32'(i);
      tb_out_ready = ((k % 4) == 0) || ((k % 4) == 3);
      @(negedge clk);
      if (tb_in_valid && in_ready_a) i++;
      @(posedge clk);
      #1;
      k++;
    end
    cap_en      = 1'b0;
    tb_in_valid = 1'b0;
    check("bp_count", 64'(seen_q.size()), 64'(8));
    for (int j = 0; j < seen_q.size(); j++) check("bp_order", 64'(seen_q[j]), 64'(2 * j));

    // Random traffic with random handshakes on both instances.
    for (int n = 0; n < 10000; n++) begin
      tb_in_valid  = ($urandom_range(0, 3) != 0);
      tb_out_ready = ($urandom_range(0, 3) != 0);
      tb_a         = $urandom();
      tb_b         = $urandom();
      tb_cin       = 1'($urandom_range(0, 1));
      tb_sub       = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 7))
        0: tb_a = 32'hFFFF_FFFF;
        1: tb_b = 32'h7FFF_FFFF;
        2: tb_a = 32'h8000_0000;
        default: ;
      endcase
      @(posedge clk);
      #1;
    end

    // Drain: nothing may remain outstanding.
    tb_in_valid  = 1'b0;
    tb_out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("drain_a", 64'(q_a.size()), 64'(0));
    check("drain_b", 64'(q_b.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipelined_carry_adder.md
Name: pipelined_carry_adder

Overview:
- Parametrised successor to the team's combinational ripple-carry adder.
- Splits a WIDTH-bit add/subtract into STAGES equal slices, one slice per clock, with the carry registered between slices.
- Accepts one operation per cycle under a valid/ready handshake with output backpressure.
- Used wherever a wide adder would break timing in the datapath.

Parameters:
- WIDTH, 32, operand/result width in bits.
- STAGES, 4, pipeline depth and number of slices. Constraint: WIDTH % STAGES == 0. Slice width SW = WIDTH/STAGES.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in (add) or borrow-in (sub).
- sub  in  1  0: s=a+b+cin; 1: s=a-b-cin.
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accepts result.
- s  out  WIDTH  result.
- cout  out  1  carry-out (add); NOT borrow-out (sub).
- ovf  out  1  two's-complement signed overflow.

Behaviour:
- Reset (async assert, sync-safe deassert by flops): out_valid=0, s=0, cout=0, ovf=0, all internal valid bits and carry registers=0. in_ready=1 after reset.
- Advance enable: adv = !out_valid || out_ready. All pipeline registers update only when adv=1; otherwise everything holds (global stall). in_ready = adv, combinational.
- Accept: beat captured when in_valid && in_ready. A cycle with adv=1 and in_valid=0 inserts a bubble (valid bit 0).
- Operand prep at capture:
  - b_eff = sub ? ~b : b.
  - c0 = sub ? ~cin : cin.
  - So sub computes a + ~b + !cin.
- Stage k (k = 0..STAGES-1):
  - Adds slice k of a and b_eff plus the carry from stage k-1 (c0 for k=0).
  - Registers the SW-bit partial sum and the slice carry-out.
- Operand skew: slices k+1..STAGES-1 are carried forward in registers until their stage. Completed lower slices are carried forward until the final stage (result deskew).
- Latency: exactly STAGES cycles from accept to out_valid=1 with no stall. Each stall cycle adds one. Throughput is 1 beat/cycle.
- Outputs (registered, from final stage):
  - s = concatenated slices.
  - cout = carry out of the top slice.
  - ovf = (carry into bit WIDTH-1) XOR cout. The carry into bit WIDTH-1 is computed within the top slice.
- Outputs are held stable while out_valid && !out_ready.
- Ordering: results emerge in acceptance order; no beat is dropped or duplicated.
- STAGES=1 degenerates to a single registered adder with latency 1.
- Reset mid-operation discards all in-flight beats. out_valid=0 on the cycle reset asserts.
- Simultaneous events:
  - With the output full and out_ready=1, the output beat retires and a new input beat is accepted in the same cycle.
  - sub and cin are sampled only with the accepted beat.

Test Plan:
- Reset: assert rst mid-stream -> out_valid=0, s=0, cout=0, ovf=0 immediately; first beat after release appears exactly 4 cycles after accept (WIDTH=32, STAGES=4).
- Full carry ripple across all slices: a=0xFFFFFFFF, b=0, cin=1, sub=0 -> s=0x00000000, cout=1, ovf=0 at latency 4.
- Subtract with borrow: a=5, b=7, cin=0, sub=1 -> s=0xFFFFFFFE, cout=0, ovf=0. Then a=7, b=5, cin=1, sub=1 -> s=1, cout=1.
- Signed overflow:
  - a=0x7FFFFFFF, b=1, add -> s=0x80000000, ovf=1, cout=0.
  - a=0x80000000, b=1, sub -> s=0x7FFFFFFF, ovf=1.
- Backpressure: stream 8 back-to-back beats (a=i, b=i) with out_ready toggling 1,0,0,1,... -> in_ready mirrors adv, s sequence = 0,2,4,...,14 in order, outputs stable during stalls, no loss.
- Random: 10k random a/b/cin/sub with random in_valid/out_ready, on WIDTH=32/STAGES=4 and WIDTH=16/STAGES=1 -> scoreboard against a reference model {cout,s} and ovf, zero mismatches.
